// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity, stop, device ACK.
// Optional watchdog on device clock edges is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_tx #(
  parameter int RTS_CYCLES     = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);
  localparam int CW = $clog2(RTS_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK, RELEASE} state_t;

  state_t          state, state_nx;
  logic [7:0]      filt_sr;
  logic            filt, filt_nx, fall;
  logic [1:0]      d_sync;
  logic            d_s;
  logic [8:0]      shift, shift_nx;
  logic [3:0]      n, n_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            c_oe, d_oe, timeout;

  // Glitch filter on the device clock: output only moves on 8 agreeing samples.
  assign filt_nx = (filt_sr == 8'hFF) ? 1'b1 :
                   (filt_sr == 8'h00) ? 1'b0 : filt;
  assign d_s     = d_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_sr <= 8'hFF;
      filt    <= 1'b1;
      fall    <= 1'b0;
      d_sync  <= 2'b11;
    end else begin
      filt_sr <= {ps2c, filt_sr[7:1]};
      filt    <= filt_nx;
      fall    <= filt & ~filt_nx;
      d_sync  <= {d_sync[0], ps2d};
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd;
  logic          active;

  assign active = (state == START) || (state == DATA) || (state == STOP) ||
                  (state == ACK)   || (state == RELEASE);

  // Cleared outside the device-clocked phases, so it is fresh on entering START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wd <= '0;
    else if (fall || !active)  wd <= '0;
    else                       wd <= wd + 1'b1;
  end

  assign timeout = active && (wd == TW'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: the parameter is kept only so both builds share one interface.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shift <= '0;
      n     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      shift <= shift_nx;
      n     <= n_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift;
    n_nx     = n;
    cnt_nx   = cnt;
    if (timeout) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:
          if (wr_ps2) begin
            shift_nx = {~^din, din};
            cnt_nx   = CW'(RTS_CYCLES - 1);
            state_nx = RTS;
          end
        RTS:
          if (cnt == '0) state_nx = START;
          else           cnt_nx   = cnt - 1'b1;
        START:
          if (fall) begin
            n_nx     = 4'd8;
            state_nx = DATA;
          end
        DATA:
          if (fall) begin
            if (n == 4'd0) begin
              state_nx = STOP;
            end else begin
              shift_nx = {1'b0, shift[8:1]};
              n_nx     = n - 1'b1;
            end
          end
        STOP:
          if (fall) state_nx = ACK;
        ACK:
          if (fall) state_nx = d_s ? IDLE : RELEASE;
        RELEASE:
          if (filt && d_s) state_nx = IDLE;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    c_oe         = 1'b0;
    d_oe         = 1'b0;
    tx_idle      = 1'b0;
    tx_done_tick = 1'b0;
    tx_err       = timeout;
    case (state)
      IDLE:    tx_idle = 1'b1;
      RTS: begin
        c_oe = 1'b1;
        d_oe = (cnt == '0);
      end
      START:   d_oe = 1'b1;
      DATA:    d_oe = ~shift[0];
      ACK:     tx_err = timeout | (fall & d_s);
      RELEASE: tx_done_tick = ~timeout & filt & d_s;
      default: ;
    endcase
  end

  assign ps2c = c_oe ? 1'b0 : 1'bz;
  assign ps2d = d_oe ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboarded bench for ps2_tx with a behavioural PS/2 device model driving the open-drain bus.
module tb_ps2_tx;
  localparam int RTS = 300;
  localparam int TO  = 2000;
  localparam int H   = 40;
  localparam int R_DONE = 1;
  localparam int R_ERR  = 2;

  logic clk = 1'b0;
  logic reset_n, wr_ps2;
  logic [7:0] din;
  wire  ps2c, ps2d;
  logic tx_idle, tx_done_tick, tx_err;
  logic dev_c = 1'b0, dev_d = 1'b0;

  assign ps2c = dev_c ? 1'b0 : 1'bz;
  assign ps2d = dev_d ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c), .ps2d(ps2d), .tx_idle(tx_idle),
    .tx_done_tick(tx_done_tick), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [10:0] bits;
    int          lo;
  } obs_t;

  obs_t        obs_q[$];
  logic [10:0] expf_q[$];
  int          expr_q[$];
  int checks = 0, errors = 0;
  int pulses = 0, err_cyc = 0, edge_n = 0, last_fall = 0;

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected wire frame {stop, parity, d7..d0, start} from the protocol rules.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0), b, 1'b0};
  endfunction

  obs_t        mo;
  logic [10:0] me;
  int          mr, got;
  always @(negedge clk) begin
    if (obs_q.size() > 0) begin
      mo = obs_q.pop_front();
      if (expf_q.size() == 0) chk(0, "frame_unexpected", int'(mo.bits), 0);
      else begin
        me = expf_q.pop_front();
        chk(mo.bits === me, "frame_bits", int'(mo.bits), int'(me));
        chk(mo.lo == RTS, "rts_low_cycles", mo.lo, RTS);
      end
    end
    if (tx_done_tick || tx_err) begin
      pulses++;
      got = tx_err ? R_ERR : R_DONE;
      if (tx_err) err_cyc = cyc;
      chk(!(tx_done_tick && tx_err), "done_and_err", 1, 0);
      if (expr_q.size() == 0) chk(0, "pulse_unexpected", got, 0);
      else begin
        mr = expr_q.pop_front();
        chk(got == mr, "pulse_kind", got, mr);
      end
    end
  end

  task automatic device(input bit ack, input int stall);
    logic [10:0] bits;
    int k, lo;
    bits = '0;
    k = 0;
    while (ps2c !== 1'b0 && k < 100) begin @(negedge clk); k++; end
    if (ps2c !== 1'b0) begin chk(0, "rts_seen", 0, 1); return; end
    lo = 0;
    while (ps2c === 1'b0 && lo < RTS + 100) begin lo++; @(negedge clk); end
    bits[0] = ps2d;
    repeat (H) @(negedge clk);
    for (int e = 1; e <= 12; e++) begin
      dev_c = 1'b1; last_fall = cyc; edge_n = e;
      repeat (H) @(negedge clk);
      dev_c = 1'b0;
      repeat (H/2) @(negedge clk);
      if (e <= 10) bits[e] = ps2d;
      if (e == 10 && ack) dev_d = 1'b1;
      if (e == 12) dev_d = 1'b0;
      repeat (H/2) @(negedge clk);
      if (e == stall) return;
    end
    obs_q.push_back('{bits: bits, lo: lo});
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    din = b; wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0; din = 8'($urandom);
    chk(tx_idle == 1'b0, "busy_after_wr", int'(tx_idle), 0);
  endtask

  task automatic send(input logic [7:0] b, input bit ack);
    int k;
    expf_q.push_back(frame_of(b));
    expr_q.push_back(ack ? R_DONE : R_ERR);
    edge_n = 0;
    start_tx(b);
    device(ack, 99);
    k = 0;
    while ((!tx_idle || expr_q.size() > 0 || obs_q.size() > 0) && k < 500) begin
      @(negedge clk); k++;
    end
    chk(k < 500, "complete", k, 500);
    chk(ps2c === 1'b1 && ps2d === 1'b1, "lines_released", int'({ps2c, ps2d}), 3);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL global_timeout: got %0d expected 0", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int p0, k, lows;
    bit saw;
    reset_n = 1'b0; wr_ps2 = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    chk(tx_idle === 1'b1, "reset_idle", int'(tx_idle), 1);
    chk(tx_done_tick === 1'b0 && tx_err === 1'b0, "reset_pulses", int'({tx_done_tick, tx_err}), 0);
    chk(ps2c === 1'b1 && ps2d === 1'b1, "reset_lines", int'({ps2c, ps2d}), 3);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with a stray request for 0xAA mid-DATA
    fork
      send(8'hED, 1'b1);
      begin
        k = 0;
        while (edge_n != 3 && k < 5000) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        din = 8'hAA; wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
    join
    lows = 0;
    repeat (50) begin @(negedge clk); if (ps2c === 1'b0) lows++; end
    chk(lows == 0, "ignored_wr_no_rts", lows, 0);

    send(8'h00, 1'b1);
    send(8'h01, 1'b1);
    send(8'hF4, 1'b0);
    chk(tx_idle === 1'b1, "nack_idle", int'(tx_idle), 1);

    for (int i = 0; i < 8; i++) send(8'($urandom), ($urandom_range(0, 4) != 0));

    // device stops clocking after 4 bits
    p0 = pulses;
`ifdef PS2_TX_TIMEOUT_EN
    expr_q.push_back(R_ERR);
`endif
    edge_n = 0;
    start_tx(8'h3C);
    device(1'b1, 4);
`ifdef PS2_TX_TIMEOUT_EN
    k = 0;
    while (pulses == p0 && k < TO + 200) begin @(negedge clk); k++; end
    chk(err_cyc - last_fall >= TO && err_cyc - last_fall <= TO + 15, "timeout_latency",
        err_cyc - last_fall, TO);
    @(negedge clk);
    chk(tx_idle === 1'b1 && ps2c === 1'b1 && ps2d === 1'b1, "timeout_released",
        int'({tx_idle, ps2c, ps2d}), 7);
`else
    repeat (3 * TO) @(negedge clk);
    chk(pulses == p0, "stall_no_err", pulses - p0, 0);
    chk(tx_idle === 1'b0, "stall_waits", int'(tx_idle), 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
`endif

    // reset while the host is driving a 0 data bit
    p0 = pulses;
    edge_n = 0;
    start_tx(8'h00);
    device(1'b1, 3);
    chk(ps2d === 1'b0 && tx_idle === 1'b0, "pre_reset_driving", int'({ps2d, tx_idle}), 0);
    reset_n = 1'b0;
    #1;
    chk(ps2c === 1'b1 && ps2d === 1'b1, "reset_immediate_lines", int'({ps2c, ps2d}), 3);
    chk(tx_idle === 1'b1, "reset_immediate_idle", int'(tx_idle), 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk(pulses == p0, "reset_silent", pulses - p0, 0);

    // 2 ns glitch straddling a rising clock edge while idle
    @(negedge clk);
    #4 dev_c = 1'b1;
    #2 dev_c = 1'b0;
    saw = 1'b0;
    repeat (30) begin @(negedge clk); if (dut.fall) saw = 1'b1; end
    chk(!saw, "glitch_no_fall", int'(saw), 0);
    chk(tx_idle === 1'b1 && pulses == p0, "glitch_quiet", pulses - p0, 0);

    send(8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    chk(expf_q.size() == 0 && expr_q.size() == 0, "scoreboard_drained",
        expf_q.size() + expr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter RTS_CYCLES, default 12000, meaning clk cycles ps2c is held low for request-to-send (120 us at 100 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000, meaning max clk cycles between device falling edges (20 ms).
REQ-003 SHALL have clk  input  1  system clock; one clock domain only.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have wr_ps2  input  1  one-cycle start request, honoured only while tx_idle=1.
REQ-006 SHALL have din  input  8  command byte to send to the device.
REQ-007 SHALL have ps2c  inout  1  PS/2 clock, open-drain: driven 0 or Z only.
REQ-008 SHALL have ps2d  inout  1  PS/2 data, open-drain: driven 0 or Z only.
REQ-009 SHALL have tx_idle  output  1  high when no transfer is active; gates rx_en of ps2_rx.
REQ-010 SHALL have tx_done_tick  output  1  one-cycle pulse: byte sent and device ACK received.
REQ-011 SHALL have tx_err  output  1  one-cycle pulse: NACK or timeout; transfer abandoned.

Function
REQ-012 SHALL filter ps2c with 8-sample shift register: filtered=1 when all ones, 0 when all zeros, else hold; fall = filtered 1->0 registered edge.
REQ-013 SHALL implement states IDLE, RTS, START, DATA, STOP, ACK, RELEASE.
REQ-014 IDLE: both lines Z, tx_idle=1; wr_ps2=1 latches shift={odd parity of din, din}, loads counter RTS_CYCLES-1, goes RTS next cycle.
REQ-015 wr_ps2 outside IDLE SHALL be ignored; din changes after acceptance SHALL not affect the transfer.
REQ-016 RTS: ps2c driven 0, ps2d driven 0 during the final cycle; counter decrements; at 0 goes START.
REQ-017 START: ps2c Z, ps2d driven 0 (start bit); on fall go DATA with bit counter 8, ps2d = shift[0].
REQ-018 DATA: ps2d driven 0 when shift[0]=0 else Z; each fall shifts right and decrements; fall with counter 0 (after parity) goes STOP.
REQ-019 Bit order on ps2d SHALL be d0..d7 LSB first, then odd parity (ones in din plus parity odd).
REQ-020 STOP: ps2d Z (stop=1); next fall goes ACK.
REQ-021 ACK: on fall sample filtered ps2d; 0 -> RELEASE with success flag, 1 -> tx_err pulse, IDLE.
REQ-022 RELEASE: wait until ps2c filtered=1 and ps2d=1, then tx_done_tick for one cycle and IDLE.
REQ-023 tx_idle SHALL be 0 in every state except IDLE, including the tick cycle's state transition.
REQ-024 ps2d input SHALL pass through a 2-flop synchronizer before sampling.

Reset
REQ-025 reset_n=0 SHALL asynchronously force IDLE, both lines Z, tx_idle=1, tx_done_tick=0, tx_err=0, filter all ones, counters 0.
REQ-026 Reset mid-transfer SHALL abort silently (no tx_err) and release both lines immediately.

Configuration
REQ-027 Macro PS2_TX_TIMEOUT_EN defined: watchdog counter reloads at each fall and on entering START; reaching TIMEOUT_CYCLES in START/DATA/STOP/ACK/RELEASE releases lines, pulses tx_err, goes IDLE.
REQ-028 Macro PS2_TX_TIMEOUT_EN undefined: no watchdog logic; block waits indefinitely for device edges; tx_err only from NACK.

Verification
REQ-029 Send 0xED with device model clocking 12.5 kHz and ACKing -> ps2c low 12000 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, one tx_done_tick, tx_idle returns 1.
REQ-030 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; both complete with tx_done_tick.
REQ-031 Device leaves ps2d high at ACK edge for 0xF4 -> one tx_err pulse, no tx_done_tick, IDLE, lines Z.
REQ-032 wr_ps2 with din=0xAA pulsed during DATA of 0xED transfer -> ignored; wire shows only 0xED.
REQ-033 With PS2_TX_TIMEOUT_EN, device stops clocking after 4 bits -> tx_err exactly TIMEOUT_CYCLES after last fall, lines Z; without macro -> stays in DATA, no tx_err.
REQ-034 reset_n low during DATA, 2 ns glitch on ps2c in IDLE -> immediate IDLE with lines Z and no pulses; glitch produces no fall.
